fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: run/step/halt sequencing, redirect and stall.
// Drives a 16-bit byte-addressed, halfword-aligned instruction memory.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] instr_in,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    output logic [1:0]  state,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_e;

    localparam logic [15:0] RESET_PC_AL = {RESET_PC[15:1], 1'b0};

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;

    logic        fetch_en;
    logic        is_halt;
    logic [15:0] redir_al;
    logic [15:0] pc_inc;

    assign redir_al = {redirect_pc[15:1], 1'b0};
    assign pc_inc   = pc_q + 16'd2;
    assign is_halt  = (instr_in == HALT_INSTR);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fetch_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ir_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redir_al;
                end
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d    = S_IDLE;
                    ir_valid_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redir_al;
                    end
                end else if (redirect_valid) begin
                    // Wrong-path squash: drop ir and restart at the target
                    pc_d       = redir_al;
                    ir_valid_d = 1'b0;
                end else if (!stall) begin
                    fetch_en = 1'b1;
                end
            end
            S_STEP: begin
                if (redirect_valid) begin
                    pc_d       = redir_al;
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (!stall) begin
                    fetch_en = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_HALT: begin
                ir_valid_d = 1'b0;
            end
        endcase

        if (fetch_en) begin
            ir_d       = instr_in;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            // A halt instruction parks pc on itself
            if (is_halt) begin
                state_d = S_HALT;
            end else begin
                pc_d = pc_inc;
            end
        end

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC_AL;
            ir_q       <= 16'h0000;
            ir_pc_q    <= 16'h0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign state    = state_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl with a small instruction memory.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] instr_in;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic [1:0]  state;
    logic        halted;

    logic [15:0] mem [0:255];

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic        run;
        logic        step;
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ir_pc;
        logic        v;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .step           (step),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_in       (instr_in),
        .pc             (pc),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .state          (state),
        .halted         (halted)
    );

    assign instr_in = mem[pc[8:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic ru, input logic sp,
                       input logic sl, input logic rv,
                       input logic [15:0] rpc, input logic [15:0] epc,
                       input logic [15:0] eir, input logic [15:0] eirpc,
                       input logic ev, input logic [1:0] est);
        vec_t t;
        t.rst_n = r;   t.run = ru;   t.step = sp;
        t.stall = sl;  t.rv = rv;    t.rpc = rpc;
        t.pc = epc;    t.ir = eir;   t.ir_pc = eirpc;
        t.v = ev;      t.st = est;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]   = 16'h0000;
        mem[1]   = 16'h3190;
        mem[2]   = 16'h33BE;
        mem[5]   = 16'hFFFF;
        mem[255] = 16'h5A5A;

        //   rst run stp stl rv rpc        pc       ir       ir_pc    v  st
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 1, 2'b01);
        add(1, 1, 0, 1, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 1, 2'b01);
        add(1, 1, 0, 1, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 1, 2'b01);
        add(1, 1, 0, 1, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 1, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0006, 16'h33BE, 16'h0004, 1, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0008, 16'h1003, 16'h0006, 1, 2'b01);
        add(1, 1, 0, 0, 1, 16'h0021, 16'h0020, 16'h1003, 16'h0006, 0, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0022, 16'h1010, 16'h0020, 1, 2'b01);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0022, 16'h1010, 16'h0020, 0, 2'b00);
        add(1, 0, 0, 0, 1, 16'h0003, 16'h0002, 16'h1010, 16'h0020, 0, 2'b00);
        add(1, 0, 1, 0, 0, 16'h0000, 16'h0002, 16'h1010, 16'h0020, 0, 2'b10);
        add(1, 0, 0, 1, 0, 16'h0000, 16'h0002, 16'h1010, 16'h0020, 0, 2'b10);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 1, 2'b00);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 0, 2'b00);
        add(1, 0, 1, 1, 0, 16'h0000, 16'h0004, 16'h3190, 16'h0002, 0, 2'b10);
        add(1, 0, 0, 1, 1, 16'h0010, 16'h0010, 16'h3190, 16'h0002, 0, 2'b00);
        add(1, 0, 0, 0, 1, 16'hFFFE, 16'hFFFE, 16'h3190, 16'h0002, 0, 2'b00);
        add(1, 1, 0, 0, 0, 16'h0000, 16'hFFFE, 16'h3190, 16'h0002, 0, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 16'hFFFE, 1, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1, 2'b01);
        add(1, 1, 0, 1, 1, 16'h000A, 16'h000A, 16'h0000, 16'h0000, 0, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h000A, 16'hFFFF, 16'h000A, 1, 2'b11);
        add(1, 1, 1, 0, 1, 16'h0040, 16'h000A, 16'hFFFF, 16'h000A, 0, 2'b11);
        add(1, 0, 1, 0, 0, 16'h0000, 16'h000A, 16'hFFFF, 16'h000A, 0, 2'b11);
        add(1, 0, 0, 1, 1, 16'h0040, 16'h000A, 16'hFFFF, 16'h000A, 0, 2'b11);
        add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b00);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b01);
        add(1, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1, 2'b01);
        add(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b00);
        add(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b01);
        add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 2'b00);

        rst_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        chk("reset pc", pc, 16'h0000);
        chk("reset ir", ir, 16'h0000);
        chk("reset ir_pc", ir_pc, 16'h0000);
        chk("reset ir_valid", 16'(ir_valid), 16'h0000);
        chk("reset state", 16'(state), 16'h0000);
        chk("reset halted", 16'(halted), 16'h0000);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            run = vecs[i].run;
            step = vecs[i].step;
            stall = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("row%0d pc", i), pc, vecs[i].pc);
            chk($sformatf("row%0d ir", i), ir, vecs[i].ir);
            chk($sformatf("row%0d ir_pc", i), ir_pc, vecs[i].ir_pc);
            chk($sformatf("row%0d ir_valid", i), 16'(ir_valid),
                16'(vecs[i].v));
            chk($sformatf("row%0d state", i), 16'(state), 16'(vecs[i].st));
            chk($sformatf("row%0d halted", i), 16'(halted),
                16'(vecs[i].st == 2'b11));
        end

        // Halt reached through IDLE start address, then inputs thrashed
        run = 1'b0;
        step = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h000B;
        tick();
        redirect_valid = 1'b0;
        run = 1'b1;
        n = 0;
        while (!halted && n < 20) begin
            tick();
            n++;
        end
        chk("halt reached", 16'(halted), 16'h0001);
        chk("halt ir_pc", ir_pc, 16'h000A);
        for (int k = 0; k < 8; k++) begin
            run = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc = 16'($urandom);
            tick();
            chk($sformatf("halt%0d pc", k), pc, 16'h000A);
            chk($sformatf("halt%0d state", k), 16'(state), 16'h0003);
            chk($sformatf("halt%0d ir", k), ir, 16'hFFFF);
            chk($sformatf("halt%0d ir_valid", k), 16'(ir_valid), 16'h0000);
        end
        rst_n = 1'b0;
        tick();
        chk("halt reset pc", pc, 16'h0000);
        chk("halt reset state", 16'(state), 16'h0000);
        chk("halt reset halted", 16'(halted), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
